// File: rtl/event_demux_pkg.sv
// Shared route codes and default widths for the event demultiplexer.
// Optional counters are enabled by defining EVENT_DEMUX_COUNT_EN.
package event_demux_pkg;

    typedef enum logic [1:0] {
        SEL_A    = 2'b00,
        SEL_B    = 2'b01,
        SEL_BOTH = 2'b10,
        SEL_DROP = 2'b11
    } sel_e;

    localparam int DEFAULT_W  = 8;
    localparam int DEFAULT_CW = 8;

endpackage

// File: rtl/event_demux_slot.sv
// One-entry valid/ready output register with an optional delivered-beat counter.
// The counter exists only when EVENT_DEMUX_COUNT_EN is defined; otherwise count is tied to 0.
module event_demux_slot
    import event_demux_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    output logic          free,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         drain;

    assign drain = valid_q & out_ready;
    // A slot draining this cycle can take a new beat in the same cycle.
    assign free  = ~valid_q | out_ready;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef EVENT_DEMUX_COUNT_EN
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (drain) count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
`else
    assign count = '0;
`endif

endmodule

// File: rtl/event_demux.sv
// Routes each input beat to output A, B, both (all-or-nothing) or nowhere.
// Build option: EVENT_DEMUX_COUNT_EN enables the a_count/b_count delivered-beat counters.
module event_demux
    import event_demux_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [W-1:0]  a_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [W-1:0]  b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [CW-1:0] a_count,
    output logic [CW-1:0] b_count
);

    sel_e sel;
    logic a_free, b_free;
    logic accept, load_a, load_b;

    assign sel = sel_e'(in_sel);

    // Broadcast waits for both slots so it can never land in only one.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            SEL_A:    in_ready = a_free;
            SEL_B:    in_ready = b_free;
            SEL_BOTH: in_ready = a_free & b_free;
            SEL_DROP: in_ready = 1'b1;
            default:  in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign load_a = accept & ((sel == SEL_A) | (sel == SEL_BOTH));
    assign load_b = accept & ((sel == SEL_B) | (sel == SEL_BOTH));

    event_demux_slot #(.W(W), .CW(CW)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .load      (load_a),
        .load_data (in_data),
        .free      (a_free),
        .out_data  (a_data),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .count     (a_count)
    );

    event_demux_slot #(.W(W), .CW(CW)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .load      (load_b),
        .load_data (in_data),
        .free      (b_free),
        .out_data  (b_data),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .count     (b_count)
    );

endmodule

// File: tb/tb_event_demux.sv
// Self-checking bench for event_demux: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_event_demux;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a_data, b_data;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [CW-1:0] a_count, b_count;

    always #5 clk = ~clk;

    event_demux #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each output holds the beats accepted for it but not yet delivered.
    logic [W-1:0]  qa[$];
    logic [W-1:0]  qb[$];
    logic [CW-1:0] m_a_cnt = '0;
    logic [CW-1:0] m_b_cnt = '0;
    bit            m_init  = 1'b0;

    function automatic bit m_in_ready();
        bit fa, fb;
        fa = (qa.size() == 0) || a_ready;
        fb = (qb.size() == 0) || b_ready;
        case (in_sel)
            2'b00:   return fa;
            2'b01:   return fb;
            2'b10:   return fa && fb;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            m_a_cnt = '0;
            m_b_cnt = '0;
            m_init  = 1'b1;
        end else begin
            bit acc;
            acc = in_valid && m_in_ready();
            if (qa.size() != 0 && a_ready) begin
                void'(qa.pop_front());
`ifdef EVENT_DEMUX_COUNT_EN
                m_a_cnt = m_a_cnt + 1'b1;
`endif
            end
            if (qb.size() != 0 && b_ready) begin
                void'(qb.pop_front());
`ifdef EVENT_DEMUX_COUNT_EN
                m_b_cnt = m_b_cnt + 1'b1;
`endif
            end
            if (acc && (in_sel == 2'b00 || in_sel == 2'b10)) qa.push_back(in_data);
            if (acc && (in_sel == 2'b01 || in_sel == 2'b10)) qb.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("m_in_ready", in_ready, m_in_ready());
            check("m_a_valid", a_valid, qa.size() != 0);
            check("m_b_valid", b_valid, qb.size() != 0);
            if (qa.size() != 0) check("m_a_data", a_data, qa[0]);
            if (qb.size() != 0) check("m_b_data", b_data, qb[0]);
            check("m_a_count", a_count, m_a_cnt);
            check("m_b_count", b_count, m_b_cnt);
        end
    end

    task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                         input bit ar, input bit br);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [CW-1:0] exp_a_cnt, exp_b_cnt;

    initial begin
        // Reset held for two cycles with a beat offered.
        rst = 1'b1;
        drive(1, 2'b00, 8'hAA, 1, 1);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 2'b00, 8'h00, 1, 1);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_data", a_data, 0);
        check("rst_b_data", b_data, 0);
        check("rst_a_count", a_count, 0);
        check("rst_b_count", b_count, 0);

        // Stream to A, one beat per cycle.
        drive(1, 2'b00, 8'h11, 1, 1); tick();
        check("str_a_valid0", a_valid, 1); check("str_a_data0", a_data, 8'h11);
        drive(1, 2'b00, 8'h22, 1, 1); tick();
        check("str_a_valid1", a_valid, 1); check("str_a_data1", a_data, 8'h22);
        drive(1, 2'b00, 8'h33, 1, 1); tick();
        check("str_a_valid2", a_valid, 1); check("str_a_data2", a_data, 8'h33);
        check("str_b_valid", b_valid, 0);
        drive(0, 2'b00, 8'h00, 1, 1); tick();
        check("str_a_idle", a_valid, 0);

        // Broadcast with B stalled.
        drive(1, 2'b10, 8'h5A, 1, 0); #1;
        check("bc_in_ready0", in_ready, 1);
        tick();
        check("bc_a_valid", a_valid, 1); check("bc_a_data", a_data, 8'h5A);
        check("bc_b_valid", b_valid, 1); check("bc_b_data", b_data, 8'h5A);
        drive(1, 2'b10, 8'h66, 1, 0); #1;
        check("bc_held0", in_ready, 0);
        tick();
        check("bc_a_drained", a_valid, 0);
        check("bc_b_hold", b_data, 8'h5A);
        check("bc_held1", in_ready, 0);
        tick();
        drive(1, 2'b10, 8'h66, 1, 1); #1;
        check("bc_release", in_ready, 1);
        tick();
        check("bc2_a_data", a_data, 8'h66); check("bc2_b_data", b_data, 8'h66);
        check("bc2_a_valid", a_valid, 1);   check("bc2_b_valid", b_valid, 1);
        drive(0, 2'b00, 8'h00, 1, 1); tick();
        check("bc_idle_a", a_valid, 0); check("bc_idle_b", b_valid, 0);

        // Backpressure on B for five cycles; A still flows.
        drive(1, 2'b01, 8'h7E, 1, 0); tick();
        check("bp_b_load", b_data, 8'h7E);
        for (int k = 0; k < 5; k++) begin
            drive(1, 2'b01, 8'h44, 1, 0); #1;
            check("bp_sel01", in_ready, 0);
            in_sel = 2'b10; #1;
            check("bp_sel10", in_ready, 0);
            if (k == 0) begin
                in_sel  = 2'b00;
                in_data = 8'h01;
                #1;
                check("bp_sel00", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp_b_valid", b_valid, 1);
            check("bp_b_data", b_data, 8'h7E);
            if (k == 0) check("bp_a_data", a_data, 8'h01);
        end
        drive(0, 2'b00, 8'h00, 1, 1); tick();
        check("bp_drained", b_valid, 0);

        // Dropped beats: always accepted, never delivered.
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b11, W'(8'hC0 + i), 1, 1); #1;
            check("drop_in_ready", in_ready, 1);
            tick();
            check("drop_a_valid", a_valid, 0);
            check("drop_b_valid", b_valid, 0);
        end
`ifdef EVENT_DEMUX_COUNT_EN
        exp_a_cnt = 8'd6; exp_b_cnt = 8'd3;
`else
        exp_a_cnt = 8'd0; exp_b_cnt = 8'd0;
`endif
        check("cnt_a_after_drop", a_count, exp_a_cnt);
        check("cnt_b_after_drop", b_count, exp_b_cnt);

        // Mixed traffic with irregular ready patterns; the model checks every cycle.
        for (int i = 0; i < 60; i++) begin
            drive((i % 5) != 4, 2'((i * 3 + i / 7) % 4), W'(i * 7 + 3),
                  (i % 3) != 0, (i % 4) < 2);
            tick();
        end
        drive(0, 2'b00, 8'h00, 1, 1); tick(); tick();

        // Reset while both slots hold a beat.
        drive(1, 2'b10, 8'h99, 0, 0); tick();
        check("mr_b_loaded", b_valid, 1);
        rst = 1'b1;
        drive(1, 2'b00, 8'h12, 1, 1); tick();
        rst = 1'b0;
        drive(0, 2'b00, 8'h00, 0, 0); #1;
        check("mr_a_valid", a_valid, 0);
        check("mr_b_valid", b_valid, 0);
        check("mr_a_count", a_count, 0);

        // 257 beats to A: counter wraps once.
        for (int i = 0; i < 257; i++) begin
            drive(1, 2'b00, W'(i), 1, 1);
            tick();
        end
        drive(0, 2'b00, 8'h00, 1, 1); tick();
`ifdef EVENT_DEMUX_COUNT_EN
        exp_a_cnt = 8'd1;
`else
        exp_a_cnt = 8'd0;
`endif
        check("wrap_a_count", a_count, exp_a_cnt);
        check("wrap_b_count", b_count, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/event_demux.md
EVENT_DEMUX -- requirements
Module: event_demux

Interface
REQ-001 SHALL have parameter W, default 8, data width in bits (1..32).
REQ-002 SHALL have parameter CW, default 8, delivered-beat counter width.
REQ-003 SHALL have one clock; reset SHALL be synchronous and active-high; ports named clk and rst.
REQ-004 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_data  in  W  input beat payload
- in_sel  in  2  route: 00=A, 01=B, 10=both, 11=drop
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid&in_ready
- a_data  out  W  output A payload
- a_valid  out  1  output A beat present
- a_ready  in  1  output A consumer accepts
- b_data  out  W  output B payload
- b_valid  out  1  output B beat present
- b_ready  in  1  output B consumer accepts
- a_count  out  CW  beats delivered on A
- b_count  out  CW  beats delivered on B

Function
REQ-005 Each output SHALL own a one-entry register slot; slot X is "free" when !x_valid, or when x_valid&x_ready this cycle.
REQ-006 in_ready SHALL be combinational: sel 00 -> A free; 01 -> B free; 10 -> A free AND B free; 11 -> 1.
REQ-007 On accept, the beat SHALL appear on the selected output(s) the next cycle (latency 1); sel 10 SHALL load both slots in the same cycle; sel 11 SHALL discard the beat.
REQ-008 x_valid SHALL stay high and x_data stable until x_ready is sampled high; valid never drops without a handshake.
REQ-009 Simultaneous drain and load of the same slot SHALL keep x_valid high and present the new beat next cycle (full throughput, 1 beat/cycle per output).
REQ-010 Beat order SHALL be preserved per output; no beat SHALL be duplicated or lost except by sel 11.
REQ-011 in_ready SHALL NOT depend on in_valid; outputs SHALL not depend combinationally on in_*.
REQ-012 Broadcast (sel 10) SHALL be all-or-nothing: never one slot loaded without the other.

Reset
REQ-013 On rst: a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0; in_ready follows REQ-006 from empty slots (=1).
REQ-014 rst mid-transfer SHALL discard held beats; no handshake completes in a cycle where rst=1.

Configuration
REQ-015 Macro EVENT_DEMUX_COUNT_EN defined: a_count/b_count SHALL increment by 1 on each a_valid&a_ready / b_valid&b_ready, wrapping 2^CW-1 -> 0.
REQ-016 Macro undefined: count ports SHALL remain present, tied to 0; no counter flops synthesised.

Structure
REQ-017 Shared package SHALL hold route codes SEL_A=2'b00, SEL_B=2'b01, SEL_BOTH=2'b10, SEL_DROP=2'b11, and counter defaults.
REQ-018 One sub-module, event_demux_slot (one-entry valid/ready register with optional counter), SHALL be instantiated twice (A, B).

Verification
REQ-019 Reset: assert rst 2 cycles with in_valid=1 -> a_valid=b_valid=0, counts=0, in_ready=1 after release.
REQ-020 Stream 0x11,0x22,0x33 sel=00, a_ready=1 -> a_data 0x11,0x22,0x33 on consecutive cycles one cycle after each accept, b_valid=0.
REQ-021 Broadcast 0x5A sel=10, a_ready=1, b_ready=0 -> both slots loaded, A drains, next sel=10 beat held off (in_ready=0) until b_ready=1.
REQ-022 Backpressure: sel=01, b_ready=0 for 5 cycles -> b_data holds 0x7E, in_ready=0 for sel 01 and 10, sel 00 beat 0x01 still passes to A.
REQ-023 Drop: 4 beats sel=11 -> in_ready=1 each cycle, no valid on A or B, counts unchanged.
REQ-024 With EVENT_DEMUX_COUNT_EN, CW=8: 257 beats to A -> a_count=1; without macro -> a_count=0.
